pci_simple_target: RTL

PCI-style target (responder) on the shared bus driven by the initiators and the arbiter. It decodes the address phase on the muxed global FRAME/IRDY/AD/CBE signals and claims accesses that hit its window. It then completes single or burst memory reads and writes against an internal 16-word register file by driving DEVSEL, TRDY and STOP. Bus strobes are active-low, matching the initiators.

---
 rtl/pci_pkg.sv | 21 ++
 rtl/pci_target_mem.sv | 26 ++
 rtl/pci_simple_target.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the simple PCI target: command codes, FSM states, window size.
package pci_pkg;

  localparam logic [3:0]  PCI_CMD_MEM_RD = 4'b0110;
  localparam logic [3:0]  PCI_CMD_MEM_WR = 4'b0111;
  localparam int unsigned PCI_WIN_WORDS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_DISC,
    ST_TURN,
    ST_SKIP
  } pci_state_e;

  function automatic logic pci_cmd_supported(input logic [3:0] cmd);
    return (cmd == PCI_CMD_MEM_RD) || (cmd == PCI_CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// 16x32 single-port register file: byte-lane write enables, combinational read.
module pci_target_mem
  import pci_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [PCI_WIN_WORDS];

  // Contents are deliberately not reset so they survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pci_simple_target.sv
// PCI-style memory target: claims a 64-byte window and serves single/burst reads and writes.
module pci_simple_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        irdy,
  input  logic [31:0] ad_in,
  input  logic [3:0]  cbe,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel,
  output logic        trdy,
  output logic        stop
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES - 1);

  pci_state_e  state, state_d;
  logic        frame_q;
  logic [3:0]  cmd_q, cmd_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        devsel_d, trdy_d, stop_d, ad_oe_d;
  logic [31:0] ad_out_d;

  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        addr_phase, hit, is_rd;

  assign addr_phase = !frame && frame_q;
  assign hit        = (ad_in[31:6] == BASE_ADDR[31:6]) && pci_cmd_supported(cbe);
  assign is_rd      = (cmd_q == PCI_CMD_MEM_RD);

  pci_target_mem u_mem (
    .clk   (clk),
    .we    (mem_we && !rst),
    .be    (~cbe),
    .addr  (mem_addr),
    .wdata (ad_in),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    devsel_d = devsel;
    trdy_d   = trdy;
    stop_d   = stop;
    ad_oe_d  = ad_oe;
    ad_out_d = ad_out;
    mem_we   = 1'b0;
    mem_addr = idx_q;

    unique case (state)
      ST_IDLE: begin
        if (addr_phase) begin
          if (hit) begin
            state_d  = ST_WAIT;
            cmd_d    = cbe;
            idx_d    = ad_in[5:2];
            cnt_d    = WAIT_INIT;
            devsel_d = 1'b0;
            ad_oe_d  = (cbe == PCI_CMD_MEM_RD);
          end else begin
            state_d = ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        if (frame && irdy) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_DATA;
          trdy_d   = 1'b0;
          ad_out_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DATA: begin
        if (!irdy) begin
          mem_we = !is_rd;
          if (frame) begin
            state_d  = ST_TURN;
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            ad_oe_d  = 1'b0;
          end else if (idx_q == 4'(PCI_WIN_WORDS - 1)) begin
            state_d = ST_DISC;
            trdy_d  = 1'b1;
            stop_d  = 1'b0;
            ad_oe_d = 1'b0;
          end else begin
            // Read port looks ahead so the next word lands on the completing edge.
            idx_d = idx_q + 4'd1;
            if (is_rd) begin
              mem_addr = idx_q + 4'd1;
              ad_out_d = mem_rdata;
            end
          end
        end
      end
      ST_DISC: begin
        if (frame) begin
          state_d  = ST_TURN;
          devsel_d = 1'b1;
          stop_d   = 1'b1;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      frame_q <= 1'b1;
      cmd_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      devsel  <= 1'b1;
      trdy    <= 1'b1;
      stop    <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= '0;
    end else begin
      state   <= state_d;
      frame_q <= frame;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      devsel  <= devsel_d;
      trdy    <= trdy_d;
      stop    <= stop_d;
      ad_oe   <= ad_oe_d;
      ad_out  <= ad_out_d;
    end
  end

endmodule
